// File: rtl/vpm_pkg.sv
// Shared definitions for the VPM issue controller: precision codes,
// controller state encoding and the legal settle-time range.
package vpm_pkg;

    // Precision codes carried on req_prec / mul_prec{1,0}
    localparam logic [1:0] PREC_8   = 2'b00;
    localparam logic [1:0] PREC_16  = 2'b01;
    localparam logic [1:0] PREC_32  = 2'b10;
    localparam logic [1:0] PREC_BAD = 2'b11;

    // Legal range of the multicycle settle time and the wait counter width
    localparam int unsigned MUL_LAT_MIN = 1;
    localparam int unsigned MUL_LAT_MAX = 8;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } vpm_state_e;

    function automatic logic prec_is_legal(input logic [1:0] prec);
        return prec != PREC_BAD;
    endfunction

endpackage

// File: rtl/vpm_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie
// the requester named by ptr wins. Purely combinational.
module vpm_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       gid
);

    // Grant decode from the request vector and the priority pointer
    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
        gid = grant[1];
    end

endmodule

// File: rtl/vpm_issue_ctrl.sv
// Issue controller sharing one combinational VPM between two requesters.
// Round-robin accept, registered VPM operands, MUL_LAT settle cycles, then
// the 64-bit product is returned on a valid/ready response channel.
// Optional performance counters are built when VPM_PERF_EN is defined.
module vpm_issue_ctrl
    import vpm_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [1:0]  req_sa,
    input  logic [1:0]  req_sb,
    input  logic [3:0]  req_prec,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_sa,
    output logic        mul_sb,
    output logic        mul_prec1,
    output logic        mul_prec0,
    input  logic [63:0] mul_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
);

    if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_bad_mul_lat
        $error("vpm_issue_ctrl: MUL_LAT out of range 1..8");
    end

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);

    vpm_state_e        state_q, state_d;
    logic              ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       mul_a_q, mul_a_d;
    logic [31:0]       mul_b_q, mul_b_d;
    logic              mul_sa_q, mul_sa_d;
    logic              mul_sb_q, mul_sb_d;
    logic [1:0]        mul_prec_q, mul_prec_d;
    logic [63:0]       rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0]        grant;
    logic              gid;
    logic              accept;
    logic              handshake;
    logic [31:0]       sel_a, sel_b;
    logic              sel_sa, sel_sb;
    logic [1:0]        sel_prec;

    vpm_rr_arb2 u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gid   (gid)
    );

    // Accept only while idle; pick the winning requester's payload
    always_comb begin
        req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
        accept    = |req_ready;
        handshake = (state_q == ST_RESP) && rsp_ready;
        sel_a     = gid ? req_a[63:32]   : req_a[31:0];
        sel_b     = gid ? req_b[63:32]   : req_b[31:0];
        sel_sa    = gid ? req_sa[1]      : req_sa[0];
        sel_sb    = gid ? req_sb[1]      : req_sb[0];
        sel_prec  = gid ? req_prec[3:2]  : req_prec[1:0];
    end

    // Next-state logic: accept/issue, settle countdown, response hold
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sa_d   = mul_sa_q;
        mul_sb_d   = mul_sb_q;
        mul_prec_d = mul_prec_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_err_d  = rsp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d    = ~gid;
                    rsp_id_d = gid;
                    if (prec_is_legal(sel_prec)) begin
                        mul_a_d    = sel_a;
                        mul_b_d    = sel_b;
                        mul_sa_d   = sel_sa;
                        mul_sb_d   = sel_sb;
                        mul_prec_d = sel_prec;
                        cnt_d      = CNT_LOAD;
                        state_d    = ST_WAIT;
                    end else begin
                        // Illegal code never reaches the VPM; mul_* keep the last issue
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d = mul_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sa_q   <= 1'b0;
            mul_sb_q   <= 1'b0;
            mul_prec_q <= '0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sa_q   <= mul_sa_d;
            mul_sb_q   <= mul_sb_d;
            mul_prec_q <= mul_prec_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_sa    = mul_sa_q;
    assign mul_sb    = mul_sb_q;
    assign mul_prec1 = mul_prec_q[1];
    assign mul_prec0 = mul_prec_q[0];
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef VPM_PERF_EN
    logic [31:0] perf_ops_q, perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Saturating event counters for completed responses and blocked cycles
    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (handshake && (perf_ops_q != '1)) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end
        if ((|req_valid) && !accept && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_vpm_issue_ctrl.sv
// Randomized scoreboard bench for vpm_issue_ctrl with a behavioural VPM.
`timescale 1ns/1ps
module tb_vpm_issue_ctrl;

    localparam int unsigned MUL_LAT   = 2;
    localparam int unsigned NEW_NONE  = 0;
    localparam int unsigned NEW_BOTH  = 1;
    localparam int unsigned NEW_RAND  = 2;
    localparam int unsigned RR_ALWAYS = 0;
    localparam int unsigned RR_NEVER  = 1;
    localparam int unsigned RR_RAND   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [63:0] req_a = '0, req_b = '0;
    logic [1:0]  req_sa = '0, req_sb = '0;
    logic [3:0]  req_prec = '0;
    logic [31:0] mul_a, mul_b;
    logic        mul_sa, mul_sb, mul_prec1, mul_prec0;
    logic [63:0] mul_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_data;
    logic        rsp_id, rsp_err, busy;
    logic [31:0] perf_ops, perf_stall;

    vpm_issue_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sa(req_sa), .req_sb(req_sb), .req_prec(req_prec),
        .mul_a(mul_a), .mul_b(mul_b), .mul_sa(mul_sa), .mul_sb(mul_sb),
        .mul_prec1(mul_prec1), .mul_prec0(mul_prec0), .mul_out(mul_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy),
        .perf_ops(perf_ops), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        id;
        logic        err;
        int unsigned rise;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0, n_fail = 0, cyc = 0;
    logic        pop_pend = 1'b0;

    // reference model state
    logic        m_ptr = 1'b0;
    logic [31:0] m_ma = '0, m_mb = '0;
    logic [3:0]  m_ctl = '0;
    int unsigned m_ops = 0, m_stall = 0;

    // requester payloads
    logic [31:0] pa[2], pb[2];
    logic        psa[2], psb[2];
    logic [1:0]  pprec[2];
    logic [1:0]  pend = '0, acc = '0;

    // Lane-wise product as seen by software: ext(a_lane) * ext(b_lane)
    function automatic logic [63:0] vpm_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb_, input logic [1:0] prec);
        logic [63:0] r, ua, ub, lmask, omask;
        int unsigned lw, nl;
        longint xa, xb, p;
        r = '0;
        if (prec == 2'b11) return r;
        lw    = 8 << prec;
        nl    = 32 / lw;
        lmask = (64'd1 << lw) - 64'd1;
        omask = (lw == 32) ? '1 : ((64'd1 << (2 * lw)) - 64'd1);
        for (int unsigned l = 0; l < nl; l++) begin
            ua = ({32'd0, a} >> (l * lw)) & lmask;
            ub = ({32'd0, b} >> (l * lw)) & lmask;
            xa = longint'(ua);
            xb = longint'(ub);
            if (sa  && ua[lw-1]) xa = xa - (longint'(1) << lw);
            if (sb_ && ub[lw-1]) xb = xb - (longint'(1) << lw);
            p = xa * xb;
            r = r | ((64'(p) & omask) << (2 * lw * l));
        end
        return r;
    endfunction

    // behavioural VPM living outside the controller
    always_comb mul_out = vpm_ref(mul_a, mul_b, mul_sa, mul_sb, {mul_prec1, mul_prec0});

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Request side: expected grant, issued operands, busy and perf counters
    initial begin : req_checker
        forever begin
            @(negedge clk);
            if (rst_n) begin : chk
                logic [1:0] exp_rdy;
                logic       g;
                logic       outstanding;
                outstanding = (sb.size() != 0);
                exp_rdy = 2'b00;
                g = 1'b0;
                if (!outstanding && (|req_valid)) begin
                    if (req_valid == 2'b01)      g = 1'b0;
                    else if (req_valid == 2'b10) g = 1'b1;
                    else                         g = m_ptr;
                    exp_rdy[g] = 1'b1;
                end
                check("req_ready", 64'(req_ready), 64'(exp_rdy));
                check("busy", 64'(busy), 64'(outstanding));
                check("mul_ab", {mul_a, mul_b}, {m_ma, m_mb});
                check("mul_ctl", 64'({mul_sa, mul_sb, mul_prec1, mul_prec0}), 64'(m_ctl));
`ifdef VPM_PERF_EN
                check("perf_ops", 64'(perf_ops), 64'(m_ops));
                check("perf_stall", 64'(perf_stall), 64'(m_stall));
`else
                check("perf_ops", 64'(perf_ops), 64'd0);
                check("perf_stall", 64'(perf_stall), 64'd0);
`endif
                if (exp_rdy != 2'b00) begin : push
                    exp_t e;
                    e.id   = g;
                    e.err  = (pprec[g] == 2'b11);
                    e.data = e.err ? 64'd0 : vpm_ref(pa[g], pb[g], psa[g], psb[g], pprec[g]);
                    e.rise = cyc + 1 + (e.err ? 0 : MUL_LAT);
                    sb.push_back(e);
                    m_ptr = ~g;
                    if (!e.err) begin
                        m_ma  = pa[g];
                        m_mb  = pb[g];
                        m_ctl = {psa[g], psb[g], pprec[g]};
                    end
                end else if (|req_valid) begin
                    m_stall++;
                end
            end
        end
    end

    // Response monitor: compares whatever the DUT presents with the queue head
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin : mon
                logic exp_v;
                exp_v = (sb.size() != 0) && (cyc >= sb[0].rise);
                check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
                if (rsp_valid && exp_v) begin
                    check("rsp_data", rsp_data, sb[0].data);
                    check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
                    check("rsp_err", 64'(rsp_err), 64'(sb[0].err));
                    if (rsp_ready) pop_pend = 1'b1;
                end
            end
        end
    end

    initial begin : popper
        forever begin
            @(posedge clk);
            if (rst_n && pop_pend) begin
                void'(sb.pop_front());
                m_ops++;
                pop_pend = 1'b0;
            end
        end
    end

    task automatic apply();
        req_valid = pend;
        req_a     = {pa[1], pa[0]};
        req_b     = {pb[1], pb[0]};
        req_sa    = {psa[1], psa[0]};
        req_sb    = {psb[1], psb[0]};
        req_prec  = {pprec[1], pprec[0]};
    endtask

    task automatic new_req(input int i, input logic allow_bad);
        int unsigned r;
        pa[i]  = $urandom;
        pb[i]  = $urandom;
        psa[i] = 1'($urandom_range(0, 1));
        psb[i] = 1'($urandom_range(0, 1));
        if (allow_bad) begin
            r = $urandom_range(0, 7);
            pprec[i] = (r < 2) ? 2'b00 : (r < 4) ? 2'b01 : (r < 7) ? 2'b10 : 2'b11;
        end else begin
            pprec[i] = 2'($urandom_range(0, 2));
        end
        pend[i] = 1'b1;
    endtask

    task automatic run(input int unsigned n, input int unsigned new_mode, input int unsigned rr_mode);
        for (int unsigned k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) pend[i] = 1'b0;
                if (!pend[i]) begin
                    if (new_mode == NEW_BOTH || (new_mode == NEW_RAND && $urandom_range(0, 2) == 0))
                        new_req(i, new_mode == NEW_RAND);
                end else if (new_mode == NEW_RAND && busy && $urandom_range(0, 15) == 0) begin
                    pend[i] = 1'b0;
                end
            end
            rsp_ready = (rr_mode == RR_ALWAYS) ? 1'b1 :
                        (rr_mode == RR_NEVER)  ? 1'b0 : ($urandom_range(0, 3) != 0);
            apply();
            @(negedge clk);
            acc = req_ready & req_valid;
        end
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        while ((sb.size() != 0 || pend != 2'b00) && k < 60) begin
            run(1, NEW_NONE, RR_ALWAYS);
            k++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_rsp_data"}, rsp_data, 64'd0);
        check({tag, "_rsp_id_err"}, 64'({rsp_id, rsp_err}), 64'd0);
        check({tag, "_mul_ab"}, {mul_a, mul_b}, 64'd0);
        check({tag, "_mul_ctl"}, 64'({mul_sa, mul_sb, mul_prec1, mul_prec0}), 64'd0);
        check({tag, "_perf"}, {perf_ops, perf_stall}, 64'd0);
    endtask

    initial begin : driver
        int unsigned k;
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0; pb[i] = '0; psa[i] = 1'b0; psb[i] = 1'b0; pprec[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        rst_n = 1'b1;

        // single req0, 32x32 signed: -1 * 2
        pa[0] = 32'hFFFF_FFFF; pb[0] = 32'd2; psa[0] = 1'b1; psb[0] = 1'b1; pprec[0] = 2'b10;
        pend[0] = 1'b1;
        run(8, NEW_NONE, RR_ALWAYS);
        drain();

        // both requesters continuously valid: grants alternate
        run(4 * (MUL_LAT + 2) + 2, NEW_BOTH, RR_ALWAYS);
        drain();

        // illegal precision on req1
        new_req(1, 1'b0);
        pprec[1] = 2'b11;
        run(6, NEW_NONE, RR_ALWAYS);
        drain();

        // response held off: outputs stable, second requester blocked
        new_req(0, 1'b0);
        new_req(1, 1'b0);
        run(14, NEW_NONE, RR_NEVER);
        run(10, NEW_NONE, RR_ALWAYS);
        drain();

        // randomized traffic with random back-pressure
        run(600, NEW_RAND, RR_RAND);
        drain();

        // reset while the multiply is settling
        new_req(0, 1'b0);
        k = 0;
        while (acc[0] == 1'b0 && k < 20) begin
            run(1, NEW_NONE, RR_ALWAYS);
            k++;
        end
        check("accept_timeout", 64'(acc[0]), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        pop_pend = 1'b0;
        m_ptr = 1'b0; m_ma = '0; m_mb = '0; m_ctl = '0; m_ops = 0; m_stall = 0;
        pend = '0; acc = '0;
        apply();
        #1;
        check_cleared("midreset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run(8, NEW_NONE, RR_ALWAYS);
        run(3 * (MUL_LAT + 2), NEW_BOTH, RR_ALWAYS);
        drain();
        run(4, NEW_NONE, RR_ALWAYS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
